fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of the requester and FIFO write ports.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive transfers per grant (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: the requester has data offered.
REQ-006 The block SHALL have ports req0_data / req1_data, input, WIDTH bits each: the offered data.
REQ-007 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each: data accepted this cycle when ready and valid are both high.
REQ-008 The block SHALL have port fifo_full, input, 1 bit: the full flag of the downstream FIFO.
REQ-009 The block SHALL have port fifo_wr_ena, output, 1 bit: the write enable to the downstream FIFO.
REQ-010 The block SHALL have port fifo_wr_data, output, WIDTH bits: the write data to the downstream FIFO.
REQ-011 The block SHALL have port grant, output, 2 bits: one-hot current owner, 2'b00 when idle.
REQ-012 The block SHALL have port xfer_cnt, output, 16 bits: total accepted transfers, wrapping at 2^16.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GNT0, GNT1; grant SHALL equal 00, 01, 10 respectively (a registered state decode).
REQ-014 reqN_ready SHALL be combinational: high only in state GNTN with fifo_full low; the non-granted ready SHALL always be low.
REQ-015 fifo_wr_ena SHALL equal the granted requester's valid AND its ready, combinationally, with zero latency.
REQ-016 fifo_wr_data SHALL equal the granted requester's data, and SHALL be 0 in IDLE.
REQ-017 fifo_wr_ena SHALL never be high while fifo_full is high.
REQ-018 Round-robin pointer last: holds the most recently granted requester; reset value 1, so requester 0 wins the first tie.
REQ-019 IDLE transitions: with neither valid, stay in IDLE; with one valid, grant it; with both valid, grant the requester not equal to last.
REQ-020 The grant SHALL take effect the cycle after the IDLE decision, so the first transfer follows valid by 1 cycle.
REQ-021 burst_cnt (4 bits) SHALL clear on every grant entry and increment on each transfer.
REQ-022 Release SHALL occur when a transfer happens with burst_cnt == MAX_BURST-1, or when the granted valid is low in GNTN.
REQ-023 On release, next state SHALL be the other GNT if the other valid is high, else the same GNT if the granted valid is high (burst-limit case, burst_cnt cleared), else IDLE; last is updated on each grant entry.
REQ-024 A high fifo_full SHALL NOT release the grant: the state and burst_cnt hold while the granted valid stays high (stall).
REQ-025 Back-to-back handover SHALL insert no idle cycle: the last transfer of GNT0 is followed immediately by GNT1 ready.
REQ-026 xfer_cnt SHALL increment by 1 on each fifo_wr_ena cycle, wrapping from 16'hFFFF to 0.

Reset
REQ-027 When rst is high at a clk edge: state goes to IDLE, last to 1, burst_cnt to 0, and xfer_cnt to 0.
REQ-028 During reset and in the cycle after it, grant, req0_ready, req1_ready and fifo_wr_ena SHALL all be 0; fifo_wr_data SHALL be 0.
REQ-029 Reset asserted mid-burst SHALL abort the grant, and no write SHALL be issued in the reset cycle.

Verification
REQ-030 Single requester: req0_valid held high with data 0x10..0x15 and MAX_BURST=4 -> 6 writes in 7 cycles (1 IDLE cycle); grant stays 01 throughout; xfer_cnt=6.
REQ-031 Contention: both valid continuously from reset -> writes alternate in bursts of 4 in the order req0,req0,req0,req0,req1 x4,req0 x4; no gap cycles after the first.
REQ-032 Full stall: in GNT1 after 2 transfers, fifo_full high for 5 cycles -> fifo_wr_ena=0 and req1_ready=0 for those 5 cycles, grant stays 10, and 2 more transfers complete the burst afterwards.
REQ-033 Early drop: req0 sends 2 words then deasserts while req1 is valid -> grant changes to 10 on the next cycle; burst_cnt restarts at 0.
REQ-034 Reset mid-burst: rst pulsed high for 1 cycle during GNT0 -> grant=00 and fifo_wr_ena=0 the next cycle; xfer_cnt=0; first grant after reset goes to req0 on a tie.
REQ-035 Wrap: preload traffic to xfer_cnt=16'hFFFE, then 3 transfers -> xfer_cnt reads FFFF, 0000, 0001.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin write arbiter in front of a single FIFO write port.
// A grant is held for up to MAX_BURST consecutive transfers. A full FIFO stalls
// the current owner without releasing the grant. Handover between requesters
// happens without an idle cycle.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             fifo_full,
  output logic             fifo_wr_ena,
  output logic [WIDTH-1:0] fifo_wr_data,
  output logic [1:0]       grant,
  output logic [15:0]      xfer_cnt
);

  // Encodings equal the grant bits, so the state register is the grant decode.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  // burst_cnt value at which a transfer ends the burst
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t      state_r, state_s;
  logic        last_r, last_s;
  logic [3:0]  burst_r, burst_s;
  logic [1:0]  grant_r, grant_s;
  logic [15:0] xfer_cnt_r;
  logic        own_valid_s, other_valid_s, wr_s;

  // Handshake path: ready, write enable and write data (zero latency, forced
  // off during reset so an aborted burst cannot write in the reset cycle).
  always_comb begin
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    fifo_wr_data = '0;
    if (rst) begin
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      fifo_wr_data = '0;
    end else begin
      req0_ready = (state_r == GNT0) && !fifo_full;
      req1_ready = (state_r == GNT1) && !fifo_full;
      case (state_r)
        GNT0:    fifo_wr_data = req0_data;
        GNT1:    fifo_wr_data = req1_data;
        default: fifo_wr_data = '0;
      endcase
    end
    wr_s        = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    fifo_wr_ena = wr_s;
  end

  // Valid of the current owner and of the other requester.
  always_comb begin
    own_valid_s   = 1'b0;
    other_valid_s = 1'b0;
    case (state_r)
      GNT0: begin
        own_valid_s   = req0_valid;
        other_valid_s = req1_valid;
      end
      GNT1: begin
        own_valid_s   = req1_valid;
        other_valid_s = req0_valid;
      end
      default: begin
        own_valid_s   = 1'b0;
        other_valid_s = 1'b0;
      end
    endcase
  end

  // Next-state logic: round-robin pick from IDLE, burst limit / drop release.
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    burst_s = burst_r;
    case (state_r)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          // tie goes to the requester that was not served last
          state_s = last_r ? GNT0 : GNT1;
          last_s  = !last_r;
          burst_s = 4'd0;
        end else if (req0_valid) begin
          state_s = GNT0;
          last_s  = 1'b0;
          burst_s = 4'd0;
        end else if (req1_valid) begin
          state_s = GNT1;
          last_s  = 1'b1;
          burst_s = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      GNT0, GNT1: begin
        if ((wr_s && (burst_r == LAST_BEAT)) || !own_valid_s) begin
          if (other_valid_s) begin
            state_s = (state_r == GNT0) ? GNT1 : GNT0;
            last_s  = (state_r == GNT0);
            burst_s = 4'd0;
          end else if (own_valid_s) begin
            // burst limit reached with nobody waiting: fresh burst, same owner
            state_s = state_r;
            last_s  = (state_r == GNT1);
            burst_s = 4'd0;
          end else begin
            state_s = IDLE;
          end
        end else if (wr_s) begin
          burst_s = burst_r + 4'd1;
        end else begin
          // stalled on a full FIFO: hold everything
          burst_s = burst_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    grant_s = state_s;
  end

  // State, round-robin pointer, burst counter, grant and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      last_r     <= 1'b1;
      burst_r    <= 4'd0;
      grant_r    <= 2'b00;
      xfer_cnt_r <= 16'd0;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
      burst_r <= burst_s;
      grant_r <= grant_s;
      if (wr_s) begin
        xfer_cnt_r <= xfer_cnt_r + 16'd1;
      end else begin
        xfer_cnt_r <= xfer_cnt_r;
      end
    end
  end

  assign grant    = rst ? 2'b00 : grant_r;
  assign xfer_cnt = xfer_cnt_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a per-cycle owner/burst model plus
// literal expectations for each directed scenario.
module tb_fifo_wr_arbiter;

  localparam int MB = 4;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        fifo_full;
  logic        fifo_wr_ena;
  logic [7:0]  fifo_wr_data;
  logic [1:0]  grant;
  logic [15:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  // model: owner -1 = nobody, words = transfers in current burst
  int m_owner = -1;
  int m_last  = 1;
  int m_words = 0;
  int m_total = 0;

  // per-cycle log of observed outputs for literal scenario checks
  logic [1:0]  g_q[$];
  logic        w_q[$];
  logic [7:0]  d_q[$];
  logic [15:0] c_q[$];

  fifo_wr_arbiter #(.WIDTH(8), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fifo_full(fifo_full), .fifo_wr_ena(fifo_wr_ena), .fifo_wr_data(fifo_wr_data),
    .grant(grant), .xfer_cnt(xfer_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Compare DUT outputs with the model, then advance the model to the next edge.
  task automatic model_step();
    logic [1:0] e_g;
    logic       e_r0, e_r1, e_w, vo, vx, done;
    logic [7:0] e_d;
    int         other;
    e_g  = rst ? 2'b00 : (m_owner == 0 ? 2'b01 : (m_owner == 1 ? 2'b10 : 2'b00));
    e_r0 = !rst && m_owner == 0 && !fifo_full;
    e_r1 = !rst && m_owner == 1 && !fifo_full;
    e_w  = (e_r0 && req0_valid) || (e_r1 && req1_valid);
    e_d  = (rst || m_owner < 0) ? 8'h00 : (m_owner == 0 ? req0_data : req1_data);
    chk("grant", {30'd0, grant}, {30'd0, e_g});
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
    chk("wr_ena", {31'd0, fifo_wr_ena}, {31'd0, e_w});
    chk("wr_data", {24'd0, fifo_wr_data}, {24'd0, e_d});
    chk("xfer_cnt", {16'd0, xfer_cnt}, m_total);
    g_q.push_back(grant);
    w_q.push_back(fifo_wr_ena);
    d_q.push_back(fifo_wr_data);
    c_q.push_back(xfer_cnt);
    if (rst) begin
      m_owner = -1; m_last = 1; m_words = 0; m_total = 0;
    end else begin
      if (e_w) m_total = (m_total + 1) % 65536;
      if (m_owner < 0) begin
        if (req0_valid && req1_valid) m_owner = 1 - m_last;
        else if (req0_valid) m_owner = 0;
        else if (req1_valid) m_owner = 1;
        if (m_owner >= 0) begin
          m_last = m_owner; m_words = 0;
        end
      end else begin
        other = 1 - m_owner;
        vo = (m_owner == 0) ? req0_valid : req1_valid;
        vx = (other == 0) ? req0_valid : req1_valid;
        done = (e_w && m_words + 1 == MB) || !vo;
        if (!done) begin
          if (e_w) m_words++;
        end else if (vx) begin
          m_owner = other; m_last = other; m_words = 0;
        end else if (vo) begin
          m_words = 0;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  // compare process: every falling edge once the first reset edge has passed
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic clear_log();
    g_q.delete(); w_q.delete(); d_q.delete(); c_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; fifo_full = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // offer n words from requester 0 (data base, base+1, ...) within a cycle budget
  task automatic send0(input int n, input logic [7:0] base, input int budget);
    int sent = 0;
    req0_valid = 1'b1;
    req0_data  = base;
    for (int c = 0; c < budget && sent < n; c++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) sent++;
      @(posedge clk); #1;
      req0_data = 8'(int'(base) + sent);
    end
    req0_valid = 1'b0;
    chk("send0_done", sent, n);
  endtask

  initial begin
    int n;
    logic [1:0] eg;
    logic [1:0] g3[10];
    logic       w3[10];
    logic [1:0] g4[8];
    logic       w4[8];
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; fifo_full = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;
    @(posedge clk); #1;

    // single requester: 6 words, one idle cycle first
    do_reset();
    clear_log();
    send0(6, 8'h10, 40);
    chk("s1_cnt", {16'd0, xfer_cnt}, 32'd6);
    chk("s1_first_idle", {31'd0, w_q[0]}, 32'd0);
    chk("s1_after_reset_grant", {30'd0, g_q[0]}, 32'd0);
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      chk("s1_grant", {30'd0, g_q[i]}, 32'd1);
      chk("s1_data", {24'd0, d_q[i]}, 32'h10 + i - 1);
      n += int'(w_q[i]);
    end
    chk("s1_writes", n, 32'd6);

    // contention from reset: bursts of 4, req0 first, no gaps
    do_reset();
    clear_log();
    req0_data = 8'hA0; req1_data = 8'hB1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cycles(14);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("s2_idle_grant", {30'd0, g_q[0]}, 32'd0);
    for (int i = 1; i <= 12; i++) begin
      eg = (((i - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      chk("s2_grant", {30'd0, g_q[i]}, {30'd0, eg});
      chk("s2_wr", {31'd0, w_q[i]}, 32'd1);
      chk("s2_data", {24'd0, d_q[i]}, (eg == 2'b01) ? 32'hA0 : 32'hB1);
    end

    // full stall in GNT1 after 2 transfers for 5 cycles
    do_reset();
    clear_log();
    req1_data = 8'hC3;
    req1_valid = 1'b1;
    cycles(3);
    fifo_full = 1'b1;
    cycles(5);
    fifo_full = 1'b0;
    cycles(2);
    req1_valid = 1'b0;
    g3 = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    w3 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      chk("s3_grant", {30'd0, g_q[i]}, {30'd0, g3[i]});
      chk("s3_wr", {31'd0, w_q[i]}, {31'd0, w3[i]});
    end
    cycles(1);
    chk("s3_cnt", {16'd0, xfer_cnt}, 32'd4);

    // early drop by req0 after 2 words while req1 waits
    do_reset();
    clear_log();
    req0_data = 8'h5A; req1_data = 8'h6B;
    req0_valid = 1'b1; req1_valid = 1'b1;
    cycles(3);
    req0_valid = 1'b0;
    cycles(5);
    req1_valid = 1'b0;
    g4 = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    w4 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      chk("s4_grant", {30'd0, g_q[i]}, {30'd0, g4[i]});
      chk("s4_wr", {31'd0, w_q[i]}, {31'd0, w4[i]});
    end
    cycles(3);

    // reset pulse mid-burst, then a tie goes to req0
    do_reset();
    clear_log();
    req0_data = 8'h77; req1_data = 8'h88;
    req0_valid = 1'b1;
    cycles(2);
    rst = 1'b1; req1_valid = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(3);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("s5_pre_grant", {30'd0, g_q[1]}, 32'd1);
    chk("s5_pre_wr", {31'd0, w_q[1]}, 32'd1);
    chk("s5_rst_grant", {30'd0, g_q[2]}, 32'd0);
    chk("s5_rst_wr", {31'd0, w_q[2]}, 32'd0);
    chk("s5_post_grant", {30'd0, g_q[3]}, 32'd0);
    chk("s5_post_wr", {31'd0, w_q[3]}, 32'd0);
    chk("s5_post_cnt", {16'd0, c_q[3]}, 32'd0);
    chk("s5_tie_grant", {30'd0, g_q[4]}, 32'd1);
    chk("s5_tie_data", {24'd0, d_q[4]}, 32'h77);
    cycles(3);

    // counter wrap: preload to FFFE then 3 more transfers
    do_reset();
    send0(65534, 8'h00, 70000);
    chk("s6_preload", {16'd0, xfer_cnt}, 32'hFFFE);
    cycles(2);
    clear_log();
    send0(3, 8'hE0, 20);
    @(negedge clk);
    chk("s6_cnt1", {16'd0, c_q[2]}, 32'hFFFF);
    chk("s6_cnt2", {16'd0, c_q[3]}, 32'h0000);
    chk("s6_cnt3", {16'd0, c_q[4]}, 32'h0001);
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
